// File: rtl/sized_data_memory.sv
// sized_data_memory: byte-addressed RV32 data memory with B/H/W loads and stores, self-clearing after reset.
// DMEM_INIT_PATTERN_EN: when defined, INIT fills word[i] = i instead of zero.
module sized_data_memory #(
  parameter int DEPTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData,
  output logic                  readValid,
  output logic                  accessFault,
  output logic                  busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_nx;
  logic [AW-1:0] init_idx, widx;
  logic [1:0] off;
  logic [31:0] mem [DEPTH];
  logic [31:0] word, init_val, wdat, ld_val;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [3:0] be;
  logic aligned, st_req, ld_req, st_ok, ld_ok, fault;
  logic unused_bits;
  assign unused_bits = ^address;
  assign busy = state == INIT;
`ifdef DMEM_INIT_PATTERN_EN
  assign init_val = 32'(init_idx);
`else
  assign init_val = 32'd0;
`endif
  always_comb begin
    widx = address[AW+1:2];
    off = address[1:0];
    st_req = state == READY && memWrite;
    ld_req = state == READY && memRead && !memWrite;
    aligned = funct3[1] ? off == 2'b00 : funct3[0] ? !off[0] : 1'b1;
    st_ok = st_req && aligned && !funct3[2] && !(funct3[1] && funct3[0]);
    ld_ok = ld_req && aligned && !(funct3[1] && funct3[0]) && !(funct3[2] && funct3[1]);
    fault = (st_req && !st_ok) || (ld_req && !ld_ok);
    be = funct3[1] ? 4'hf : funct3[0] ? 4'b0011 << off : 4'b0001 << off;
    wdat = funct3[1] ? writeData : funct3[0] ? {2{writeData[15:0]}} : {4{writeData[7:0]}};
    word = mem[widx];
    ld_b = 8'(word >> {off, 3'b000});
    ld_h = 16'(word >> {off[1], 4'b0000});
    ld_val = funct3[1] ? word
           : funct3[0] ? {{16{ld_h[15] && !funct3[2]}}, ld_h}
           : {{24{ld_b[7] && !funct3[2]}}, ld_b};
    state_nx = (state == INIT && init_idx == AW'(DEPTH - 1)) ? READY : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      init_idx <= '0;
      readData <= '0;
      readValid <= 1'b0;
      accessFault <= 1'b0;
    end else begin
      state <= state_nx;
      init_idx <= busy ? init_idx + 1'b1 : init_idx;
      readValid <= ld_req;
      accessFault <= fault;
      if (ld_req) readData <= ld_ok ? ld_val : 32'd0;
    end
  end
  // Memory has no reset of its own; the INIT sweep clears it instead.
  always_ff @(posedge clock) begin
    if (!reset && busy) mem[init_idx] <= init_val;
    else if (!reset && st_ok)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
  end
endmodule

// File: tb/tb_sized_data_memory.sv
// tb_sized_data_memory: random and directed checks of sized_data_memory against a byte-array model.
module tb_sized_data_memory;
  localparam int DEPTH = 32;
`ifdef DMEM_INIT_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, memRead = 1'b0, memWrite = 1'b0;
  logic [2:0] funct3 = 3'd0;
  logic [31:0] address = 32'd0, writeData = 32'd0;
  logic [31:0] readData;
  logic readValid, accessFault, busy;
  int n_chk = 0, n_pass = 0;
  logic [7:0] mdl [4*DEPTH];
  logic [31:0] exp_rd;

  sized_data_memory #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .address(address), .writeData(writeData),
    .readData(readData), .readValid(readValid), .accessFault(accessFault), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic mdl_init();
    for (int i = 0; i < 4*DEPTH; i++) mdl[i] = (PAT && i % 4 == 0) ? 8'(i / 4) : 8'h00;
    exp_rd = 32'd0;
  endtask

  task automatic op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sz, ba;
    bit legal, ld, req;
    logic [31:0] v;
    @(negedge clock);
    memRead = rd; memWrite = wr; funct3 = f3; address = a; writeData = wd;
    sz = 1 << f3[1:0];
    ba = int'(a % 32'(4*DEPTH));
    legal = (wr ? f3 <= 3'd2 : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5)) && (ba % sz == 0);
    ld = rd && !wr;
    req = rd || wr;
    v = 32'd0;
    if (ld && legal) begin
      for (int k = sz - 1; k >= 0; k--) v = (v << 8) | 32'(mdl[ba + k]);
      if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    end
    if (ld) exp_rd = v;
    if (wr && legal) for (int k = 0; k < sz; k++) mdl[ba + k] = 8'(wd >> (8*k));
    @(posedge clock); #1;
    check("readValid", 32'(readValid), 32'(ld));
    check("accessFault", 32'(accessFault), 32'(req && !legal));
    check("readData", readData, exp_rd);
    check("busy", 32'(busy), 32'd0);
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  task automatic init_seq(input int abort_at, input bit noise);
    int cyc;
    cyc = 0;
    @(negedge clock);
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0;
    @(posedge clock); #1;
    check("rst_readData", readData, 32'd0);
    check("rst_readValid", 32'(readValid), 32'd0);
    check("rst_accessFault", 32'(accessFault), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    mdl_init();
    @(negedge clock);
    reset = 1'b0;
    while (cyc < 200) begin
      if (noise) begin
        memWrite = 1'b1; memRead = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom_range(0, 2)); writeData = 32'hFFFFFFFF;
        address = (cyc == 0) ? 32'd0 : 32'($urandom_range(0, DEPTH - 1) * 4);
      end
      @(posedge clock); #1;
      cyc++;
      check("init_readValid", 32'(readValid), 32'd0);
      check("init_accessFault", 32'(accessFault), 32'd0);
      if (!busy || cyc == abort_at) break;
      @(negedge clock);
    end
    memRead = 1'b0; memWrite = 1'b0;
    if (abort_at == 0) check("init_len", 32'(cyc), 32'(DEPTH));
  endtask

  initial begin
    logic [31:0] a;
    init_seq(0, 1'b0);
    op(1, 0, 3'b010, 32'h14, 0);         check("t1_lw14", readData, PAT ? 32'd5 : 32'd0);
    op(0, 1, 3'b010, 32'h08, 32'hDEADBEEF);
    op(1, 0, 3'b000, 32'h0B, 0);         check("t2_lb", readData, 32'hFFFFFFDE);
    op(1, 0, 3'b100, 32'h0B, 0);         check("t2_lbu", readData, 32'h000000DE);
    op(1, 0, 3'b001, 32'h0A, 0);         check("t2_lh", readData, 32'hFFFFDEAD);
    op(1, 0, 3'b101, 32'h08, 0);         check("t2_lhu", readData, 32'h0000BEEF);
    op(0, 1, 3'b000, 32'h11, 32'h5A);
    op(1, 0, 3'b010, 32'h10, 0);         check("t3_sb", readData, PAT ? 32'h00005A04 : 32'h00005A00);
    op(0, 1, 3'b001, 32'h12, 32'h1234);
    op(1, 0, 3'b010, 32'h10, 0);         check("t3_sh", readData, PAT ? 32'h12345A04 : 32'h12345A00);
    op(1, 0, 3'b010, 32'h06, 0);
    check("t4_lw_mis_af", 32'(accessFault), 32'd1);
    check("t4_lw_mis_rv", 32'(readValid), 32'd1);
    check("t4_lw_mis_rd", readData, 32'd0);
    op(0, 1, 3'b001, 32'h03, 32'hFFFF);  check("t4_sh_mis_af", 32'(accessFault), 32'd1);
    op(1, 0, 3'b010, 32'h00, 0);         check("t4_lw0", readData, 32'd0);
    op(1, 0, 3'b011, 32'h00, 0);         check("t4_f3_011", 32'(accessFault), 32'd1);
    op(1, 0, 3'b010, 32'h84, 0);         check("t5_wrap", readData, PAT ? 32'd1 : 32'd0);
    op(1, 1, 3'b010, 32'h1C, 32'hA5A5A5A5); check("t5_both_rv", 32'(readValid), 32'd0);
    op(1, 0, 3'b010, 32'h1C, 0);         check("t5_both_lw", readData, 32'hA5A5A5A5);
    repeat (400) begin
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
    end
    init_seq(10, 1'b0);
    init_seq(0, 1'b1);
    op(1, 0, 3'b010, 32'h00, 0);         check("t6_lw0", readData, 32'd0);
    repeat (100) begin
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
